rob_iq: RTL and testbench
=========================

Name: rob_iq

Overview:
- Parametrised reorder buffer with a unified issue queue, for the out-of-order core between decode/rename and the execute stage.
- Holds renamed micro-ops in program order and wakes their operands when a producer commits.
- Each cycle it selects the oldest ready op whose functional unit is free, and commits in order from the head.
- Supports mispredict flush with drain and recovery, and exports occupancy.
- Generalises the fixed 8-entry stage to any power-of-two depth, FU count and payload width. Adds an explicit occupancy count, a configurable flush-drain policy and a separate opaque payload.

Parameters:
- DEPTH, 8: number of entries; power of two, 4..32.
- IDX_W, $clog2(DEPTH): width of an entry index.
- PR_W, 7: physical register index width.
- AR_W, 6: architectural register index width.
- NUM_FU, 5: number of functional units; fu_ready width.
- DATA_W, 32: writeback data width.
- PAY_W, 64: opaque issue payload (pc, imm, op, f3, f7, lsq idx); stored and forwarded, never interpreted.
- DRAIN_ON_FLUSH, 1: 1 = block dispatch until the buffer empties after a flush; 0 = resume after the 1-cycle RECOVER state.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  accept dispatch.
- disp_rs1, disp_rs2  in  PR_W  source physical registers.
- disp_rs1_rdy, disp_rs2_rdy  in  1  source already available.
- disp_prd_new, disp_prd_old  in  PR_W  new/old destination mapping.
- disp_ard  in  AR_W  architectural destination.
- disp_has_rd  in  1  op writes a register.
- disp_fu  in  $clog2(NUM_FU)  target FU.
- disp_payload  in  PAY_W  opaque payload.
- fu_ready  in  NUM_FU  FU can accept an op this cycle.
- iss_valid  out  1  registered issue valid.
- iss_idx  out  IDX_W  issued entry index.
- iss_rs1, iss_rs2  out  PR_W  source registers for register-file read.
- iss_fu  out  $clog2(NUM_FU)  target FU.
- iss_payload  out  PAY_W  payload of the issued entry.
- wb_valid  in  1  writeback.
- wb_idx  in  IDX_W  entry being written back.
- wb_data  in  DATA_W  result.
- mispredict  in  1  flush request.
- mis_idx  in  IDX_W  entry of the mispredicted branch; it is kept, younger entries are squashed.
- commit  out  1  head retires this cycle.
- commit_idx  out  IDX_W  head index.
- commit_wb_en  out  1  commit writes a register (has_rd && ard != 0).
- commit_prd_new, commit_prd_old  out  PR_W  mappings for freelist/RAT.
- commit_ard  out  AR_W  architectural destination.
- commit_data  out  DATA_W  result data.
- recovery  out  1  high for the single RECOVER cycle.
- rob_tail  out  IDX_W  tail pointer.
- rob_count  out  IDX_W+1  occupancy.

Behaviour:
- Reset: head = tail = 0, count = 0, all entries invalid, FSM = REGULAR. iss_valid = 0, iss_* = 0, recovery = 0, commit = 0.
- Full = (count == DEPTH); empty = (count == 0). No bypass: a full buffer refuses dispatch even if commit frees a slot that same cycle.
- disp_ready = (state == REGULAR) && !full && !mispredict.
- Dispatch on disp_valid && disp_ready:
  - writes entry[tail] with valid = 1, issued = 0, done = 0;
  - tail = tail + 1, wrapping mod DEPTH.
- Wakeup: when commit && commit_wb_en, every valid, non-flushed entry whose rs matches commit_prd_new gets that rdy bit set next cycle.
- The same-cycle match counts as ready for select, so an op can issue in the same cycle its producer commits.
- Select (combinational):
  - candidates are valid && !issued && !flushed && rs1 ready && rs2 ready && fu_ready[fu];
  - the oldest candidate in order head, head+1, … wins.
- Issue latency: iss_* is registered, 1 cycle after select.
- On issue the entry is marked issued. If has_rd = 0, done is set at issue; no writeback is expected.
- With no candidate: iss_valid = 0 and iss_* = 0.
- Writeback: wb_valid sets done and stores data on entry[wb_idx]. A write to an invalid or just-flushed entry is ignored.
- Commit = entry[head].valid && entry[head].done; all commit_* outputs come combinationally from the head.
- On commit the head entry is cleared and head increments.
- Flush: the mask marks entries strictly younger than mis_idx, in age order from head, with wrap-around. If mis_idx is the youngest entry, the mask is empty.
  - Masked entries are cleared next cycle; tail = mis_idx + 1.
  - A commit in the same cycle still proceeds.
- Count update: count_next = count + push - pop - popcount(mask).
- FSM:
  - REGULAR -> PENDING when mispredict.
  - PENDING -> RECOVER when (DRAIN_ON_FLUSH ? empty : 1).
  - RECOVER -> REGULAR unconditionally.
- Priority within a cycle: rst > flush clear > writeback > issue > dispatch on the same entry. Dispatch never collides with flush because disp_ready is low.
- rst asserted mid-operation restores the reset state in one cycle regardless of FSM state.

Decomposition:
- Package rob_pkg holds:
  - the rob_entry_t typedef (parametrised via macro widths);
  - the FSM enum REGULAR/PENDING/RECOVER;
  - an age-order helper function that rotates by head.
- Sub-module rob_age_select: a parametrised oldest-first picker taking a candidate vector and head, returning found and idx. It is reused for flush mask generation.

Test Plan:
- Fill/drain: dispatch 8 ops with rdy = 1 and has_rd = 1, wb each -> disp_ready = 0 at count = 8; commits in order with commit_idx 0..7; count returns to 0; head/tail wrap to 0.
- Wakeup bypass: op A (prd 40) at idx 0, op B with rs1 = 40, rdy = 0 -> B issues (iss_valid = 1, iss_idx = 1) the cycle after A commits, not earlier.
- Oldest-first with FU stall: entries 2,3 ready, fu_ready[fu of 2] = 0 -> idx 3 issues; then fu_ready = 1 -> idx 2 issues.
- Flush with wrap: head = 6, tail = 3 (count 5), mispredict with mis_idx = 7 -> entries 0,1,2 cleared, tail = 0, count = 2; wb to idx 1 ignored; FSM reaches RECOVER only after count = 0 (DRAIN_ON_FLUSH = 1).
- Simultaneous commit + flush + dispatch attempt: head done, mispredict same cycle, disp_valid = 1 -> commit = 1, disp_ready = 0, count = count - 1 - squashed.
- Reset mid-PENDING: rst during drain -> next cycle count = 0, recovery = 0, disp_ready = 1.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and the age-order helper for the reorder buffer / issue queue.
package rob_pkg;

  localparam int unsigned AGE_MAX = 32;
  localparam int unsigned AGE_IW  = 5;

  typedef enum logic [1:0] {
    REGULAR = 2'd0,
    PENDING = 2'd1,
    RECOVER = 2'd2
  } rob_state_t;

  // Per-entry control flags; wide fields live in separate parametrised arrays.
  typedef struct packed {
    logic valid;
    logic issued;
    logic done;
    logic rs1_rdy;
    logic rs2_rdy;
    logic has_rd;
  } rob_entry_t;

  // Rotate so that bit 0 of the result is the entry at head (oldest first).
  function automatic logic [AGE_MAX-1:0] age_rotate(input logic [AGE_MAX-1:0] vec,
                                                    input logic [AGE_IW-1:0]  head,
                                                    input int unsigned        depth);
    logic [AGE_MAX-1:0] rot;
    rot = '0;
    for (int unsigned i = 0; i < AGE_MAX; i++) begin
      if (i < depth) rot[i] = vec[AGE_IW'((32'(head) + i) % depth)];
    end
    return rot;
  endfunction

endpackage

// File: rtl/rob_age_select.sv
// Oldest-first picker over a circular buffer; also marks entries younger than the pick.
module rob_age_select
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] cand,
  input  logic [IDX_W-1:0] head,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [DEPTH-1:0] younger
);

  logic [DEPTH-1:0] rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    rot   = DEPTH'(age_rotate(AGE_MAX'(cand), AGE_IW'(head), DEPTH));
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
    idx     = head + off;
    younger = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (found && (IDX_W'(i) > off)) younger[head + IDX_W'(i)] = 1'b1;
    end
  end

endmodule

// File: rtl/rob_iq.sv
// Reorder buffer with unified issue queue: in-order dispatch/commit, oldest-ready issue,
// commit-driven wakeup and mispredict flush with drain/recovery.
module rob_iq
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned IDX_W          = $clog2(DEPTH),
  parameter int unsigned PR_W           = 7,
  parameter int unsigned AR_W           = 6,
  parameter int unsigned NUM_FU         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned PAY_W          = 64,
  parameter bit          DRAIN_ON_FLUSH = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [PR_W-1:0]           disp_rs1,
  input  logic [PR_W-1:0]           disp_rs2,
  input  logic                      disp_rs1_rdy,
  input  logic                      disp_rs2_rdy,
  input  logic [PR_W-1:0]           disp_prd_new,
  input  logic [PR_W-1:0]           disp_prd_old,
  input  logic [AR_W-1:0]           disp_ard,
  input  logic                      disp_has_rd,
  input  logic [$clog2(NUM_FU)-1:0] disp_fu,
  input  logic [PAY_W-1:0]          disp_payload,
  input  logic [NUM_FU-1:0]         fu_ready,
  output logic                      iss_valid,
  output logic [IDX_W-1:0]          iss_idx,
  output logic [PR_W-1:0]           iss_rs1,
  output logic [PR_W-1:0]           iss_rs2,
  output logic [$clog2(NUM_FU)-1:0] iss_fu,
  output logic [PAY_W-1:0]          iss_payload,
  input  logic                      wb_valid,
  input  logic [IDX_W-1:0]          wb_idx,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      mispredict,
  input  logic [IDX_W-1:0]          mis_idx,
  output logic                      commit,
  output logic [IDX_W-1:0]          commit_idx,
  output logic                      commit_wb_en,
  output logic [PR_W-1:0]           commit_prd_new,
  output logic [PR_W-1:0]           commit_prd_old,
  output logic [AR_W-1:0]           commit_ard,
  output logic [DATA_W-1:0]         commit_data,
  output logic                      recovery,
  output logic [IDX_W-1:0]          rob_tail,
  output logic [IDX_W:0]            rob_count
);

  localparam int unsigned FU_W  = $clog2(NUM_FU);
  localparam int unsigned CNT_W = IDX_W + 1;

  rob_entry_t        ent     [DEPTH];
  logic [PR_W-1:0]   rs1_q   [DEPTH];
  logic [PR_W-1:0]   rs2_q   [DEPTH];
  logic [PR_W-1:0]   prdn_q  [DEPTH];
  logic [PR_W-1:0]   prdo_q  [DEPTH];
  logic [AR_W-1:0]   ard_q   [DEPTH];
  logic [FU_W-1:0]   fu_q    [DEPTH];
  logic [PAY_W-1:0]  pay_q   [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  logic [IDX_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_next, squash_n;
  rob_state_t        state;

  logic              full, empty, push;
  logic [DEPTH-1:0]  mis_onehot, flush_younger, flush_mask;
  logic [DEPTH-1:0]  wake1, wake2, cand;
  logic              flush_found, sel_found;
  logic [IDX_W-1:0]  flush_idx, sel_idx;
  logic [DEPTH-1:0]  sel_younger_unused;

  assign rob_tail  = tail;
  assign rob_count = count;

  // Handshake and head-of-buffer commit view.
  always_comb begin
    full           = (count == CNT_W'(DEPTH));
    empty          = (count == '0);
    disp_ready     = (state == REGULAR) && !full && !mispredict;
    push           = disp_valid && disp_ready;
    commit         = ent[head].valid && ent[head].done;
    commit_idx     = head;
    commit_wb_en   = ent[head].has_rd && (ard_q[head] != '0);
    commit_prd_new = prdn_q[head];
    commit_prd_old = prdo_q[head];
    commit_ard     = ard_q[head];
    commit_data    = data_q[head];
    mis_onehot     = '0;
    if (mispredict) mis_onehot[mis_idx] = 1'b1;
  end

  // Wakeup, flush mask, issue candidates and occupancy update.
  always_comb begin
    squash_n = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wake1[i]      = commit && commit_wb_en && (rs1_q[i] == commit_prd_new);
      wake2[i]      = commit && commit_wb_en && (rs2_q[i] == commit_prd_new);
      flush_mask[i] = flush_younger[i] && ent[i].valid;
      cand[i]       = ent[i].valid && !ent[i].issued && !flush_mask[i]
                      && (ent[i].rs1_rdy || wake1[i]) && (ent[i].rs2_rdy || wake2[i])
                      && (32'(fu_q[i]) < NUM_FU) && fu_ready[fu_q[i]];
      squash_n      = squash_n + CNT_W'(flush_mask[i]);
    end
    count_next = count + CNT_W'(push) - CNT_W'(commit) - squash_n;
  end

  rob_age_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_flush (
    .cand    (mis_onehot),
    .head    (head),
    .found   (flush_found),
    .idx     (flush_idx),
    .younger (flush_younger)
  );

  rob_age_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
    .cand    (cand),
    .head    (head),
    .found   (sel_found),
    .idx     (sel_idx),
    .younger (sel_younger_unused)
  );

  // Entry storage; later assignments win: flush clear over writeback/issue, commit clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      iss_valid   <= 1'b0;
      iss_idx     <= '0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
      iss_fu      <= '0;
      iss_payload <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      count <= count_next;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent[i].valid && !flush_mask[i]) begin
          if (wake1[i]) ent[i].rs1_rdy <= 1'b1;
          if (wake2[i]) ent[i].rs2_rdy <= 1'b1;
        end
      end
      if (wb_valid && ent[wb_idx].valid && !flush_mask[wb_idx]) begin
        ent[wb_idx].done <= 1'b1;
        data_q[wb_idx]   <= wb_data;
      end
      if (sel_found) begin
        ent[sel_idx].issued <= 1'b1;
        if (!ent[sel_idx].has_rd) ent[sel_idx].done <= 1'b1;
      end
      iss_valid   <= sel_found;
      iss_idx     <= sel_found ? sel_idx : '0;
      iss_rs1     <= sel_found ? rs1_q[sel_idx] : '0;
      iss_rs2     <= sel_found ? rs2_q[sel_idx] : '0;
      iss_fu      <= sel_found ? fu_q[sel_idx] : '0;
      iss_payload <= sel_found ? pay_q[sel_idx] : '0;
      if (commit) begin
        ent[head] <= '0;
        head      <= head + IDX_W'(1);
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (flush_mask[i]) ent[i] <= '0;
      end
      if (flush_found) begin
        tail <= flush_idx + IDX_W'(1);
      end else if (push) begin
        ent[tail]    <= '{valid: 1'b1, issued: 1'b0, done: 1'b0, rs1_rdy: disp_rs1_rdy,
                          rs2_rdy: disp_rs2_rdy, has_rd: disp_has_rd};
        rs1_q[tail]  <= disp_rs1;
        rs2_q[tail]  <= disp_rs2;
        prdn_q[tail] <= disp_prd_new;
        prdo_q[tail] <= disp_prd_old;
        ard_q[tail]  <= disp_ard;
        fu_q[tail]   <= disp_fu;
        pay_q[tail]  <= disp_payload;
        data_q[tail] <= '0;
        tail         <= tail + IDX_W'(1);
      end
    end
  end

  // Flush sequencing: wait (optionally for drain), one recovery cycle, then resume.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REGULAR;
      recovery <= 1'b0;
    end else begin
      recovery <= 1'b0;
      case (state)
        REGULAR: if (mispredict) state <= PENDING;
        PENDING: begin
          if (!DRAIN_ON_FLUSH || empty) begin
            state    <= RECOVER;
            recovery <= 1'b1;
          end
        end
        RECOVER: state <= REGULAR;
        default: state <= REGULAR;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_iq.sv
// Randomised bench for rob_iq against a queue-based program-order model.
module tb_rob_iq;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned PR_W   = 7;
  localparam int unsigned AR_W   = 6;
  localparam int unsigned NUM_FU = 5;
  localparam int unsigned FU_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAY_W  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_valid, disp_ready;
  logic [PR_W-1:0]   disp_rs1, disp_rs2, disp_prd_new, disp_prd_old;
  logic              disp_rs1_rdy, disp_rs2_rdy, disp_has_rd;
  logic [AR_W-1:0]   disp_ard;
  logic [FU_W-1:0]   disp_fu;
  logic [PAY_W-1:0]  disp_payload;
  logic [NUM_FU-1:0] fu_ready;
  logic              iss_valid;
  logic [IDX_W-1:0]  iss_idx;
  logic [PR_W-1:0]   iss_rs1, iss_rs2;
  logic [FU_W-1:0]   iss_fu;
  logic [PAY_W-1:0]  iss_payload;
  logic              wb_valid;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              mispredict;
  logic [IDX_W-1:0]  mis_idx;
  logic              commit, commit_wb_en, recovery;
  logic [IDX_W-1:0]  commit_idx, rob_tail;
  logic [PR_W-1:0]   commit_prd_new, commit_prd_old;
  logic [AR_W-1:0]   commit_ard;
  logic [DATA_W-1:0] commit_data;
  logic [IDX_W:0]    rob_count;

  rob_iq #(
    .DEPTH(DEPTH), .PR_W(PR_W), .AR_W(AR_W), .NUM_FU(NUM_FU),
    .DATA_W(DATA_W), .PAY_W(PAY_W), .DRAIN_ON_FLUSH(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_prd_new(disp_prd_new), .disp_prd_old(disp_prd_old),
    .disp_ard(disp_ard), .disp_has_rd(disp_has_rd), .disp_fu(disp_fu),
    .disp_payload(disp_payload), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_idx(iss_idx), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_fu(iss_fu), .iss_payload(iss_payload),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .mispredict(mispredict), .mis_idx(mis_idx),
    .commit(commit), .commit_idx(commit_idx), .commit_wb_en(commit_wb_en),
    .commit_prd_new(commit_prd_new), .commit_prd_old(commit_prd_old),
    .commit_ard(commit_ard), .commit_data(commit_data),
    .recovery(recovery), .rob_tail(rob_tail), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              idx;
    logic [PR_W-1:0] rs1, rs2, pn, po;
    bit              r1, r2;
    logic [AR_W-1:0] ard;
    bit              has_rd;
    int              fu;
    logic [PAY_W-1:0]  pay;
    bit              issued, done;
    logic [DATA_W-1:0] data;
  } op_t;

  // Model: q holds in-flight ops oldest first; m_state 0=regular, 1=pending, 2=recover.
  op_t              q[$];
  int               m_head, m_state;
  bit               m_rec, m_iss_v;
  int               m_iss_idx, m_iss_fu;
  logic [PR_W-1:0]  m_iss_rs1, m_iss_rs2;
  logic [PAY_W-1:0] m_iss_pay;
  int               n_cmp, n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0; m_state = 0; m_rec = 0;
    m_iss_v = 0; m_iss_idx = 0; m_iss_fu = 0;
    m_iss_rs1 = '0; m_iss_rs2 = '0; m_iss_pay = '0;
  endtask

  // Either an already-ready source or one waiting on an older, still-running producer.
  task automatic pick_src(output logic [PR_W-1:0] rs, output logic rdy);
    int p[$];
    foreach (q[k]) if (q[k].has_rd && q[k].ard != 0 && !q[k].done) p.push_back(k);
    if (p.size() != 0 && $urandom_range(0, 1) == 1) begin
      rs  = q[p[$urandom_range(0, p.size() - 1)]].pn;
      rdy = 1'b0;
    end else begin
      rs  = PR_W'($urandom_range(32, 47));
      rdy = 1'b1;
    end
  endtask

  task automatic drive_random(input int cyc);
    int w[$];
    int wb_pct;
    rst = ($urandom_range(0, 399) == 0) ||
          (m_state == 1 && q.size() > 0 && $urandom_range(0, 7) == 0);
    disp_valid   = ($urandom_range(0, 3) != 0);
    pick_src(disp_rs1, disp_rs1_rdy);
    pick_src(disp_rs2, disp_rs2_rdy);
    disp_prd_new = PR_W'($urandom_range(32, 47));
    disp_prd_old = PR_W'($urandom_range(0, 127));
    disp_ard     = AR_W'($urandom_range(0, 3));
    disp_has_rd  = ($urandom_range(0, 4) != 0);
    disp_fu      = FU_W'($urandom_range(0, NUM_FU - 1));
    disp_payload = {$urandom, $urandom};
    fu_ready     = ($urandom_range(0, 3) == 0) ? '1 : NUM_FU'($urandom);
    wb_pct       = ((cyc / 256) % 2 == 1) ? 70 : 20;
    foreach (q[k]) if (q[k].issued && !q[k].done) w.push_back(q[k].idx);
    wb_valid = 1'b0;
    wb_idx   = '0;
    wb_data  = $urandom;
    if (w.size() != 0 && $urandom_range(0, 99) < wb_pct) begin
      wb_valid = 1'b1;
      wb_idx   = IDX_W'(w[$urandom_range(0, w.size() - 1)]);
    end else if ($urandom_range(0, 19) == 0) begin
      wb_valid = 1'b1;
      wb_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
    end
    mispredict = 1'b0;
    mis_idx    = IDX_W'($urandom_range(0, DEPTH - 1));
    if (q.size() != 0 && $urandom_range(0, 24) == 0) begin
      mispredict = 1'b1;
      mis_idx    = IDX_W'(q[$urandom_range(0, q.size() - 1)].idx);
    end
  endtask

  task automatic model_step();
    bit comm, wben, dr;
    logic [PR_W-1:0] cpn;
    int keep, sel, tail_now, size_now, ns;
    op_t n;
    if (rst) begin
      model_reset();
      return;
    end
    size_now = q.size();
    tail_now = (m_head + size_now) % DEPTH;
    comm = (size_now > 0) && q[0].done;
    wben = comm && q[0].has_rd && (q[0].ard != 0);
    cpn  = comm ? q[0].pn : '0;
    dr   = (m_state == 0) && (size_now < DEPTH) && !mispredict;
    keep = size_now;
    if (mispredict) foreach (q[k]) if (q[k].idx == int'(mis_idx)) keep = k + 1;
    sel = -1;
    for (int k = 0; k < keep && sel < 0; k++) begin
      if (!q[k].issued && (q[k].r1 || (wben && q[k].rs1 == cpn)) &&
          (q[k].r2 || (wben && q[k].rs2 == cpn)) && fu_ready[q[k].fu]) sel = k;
    end
    m_iss_v   = (sel >= 0);
    m_iss_idx = (sel >= 0) ? q[sel].idx : 0;
    m_iss_rs1 = (sel >= 0) ? q[sel].rs1 : '0;
    m_iss_rs2 = (sel >= 0) ? q[sel].rs2 : '0;
    m_iss_fu  = (sel >= 0) ? q[sel].fu : 0;
    m_iss_pay = (sel >= 0) ? q[sel].pay : '0;
    for (int k = 0; k < keep; k++) begin
      if (wben && q[k].rs1 == cpn) q[k].r1 = 1;
      if (wben && q[k].rs2 == cpn) q[k].r2 = 1;
      if (wb_valid && q[k].idx == int'(wb_idx)) begin
        q[k].done = 1;
        q[k].data = wb_data;
      end
    end
    if (sel >= 0) begin
      q[sel].issued = 1;
      if (!q[sel].has_rd) q[sel].done = 1;
    end
    while (q.size() > keep) void'(q.pop_back());
    if (comm) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (disp_valid && dr) begin
      n.idx = tail_now; n.rs1 = disp_rs1; n.rs2 = disp_rs2;
      n.r1 = disp_rs1_rdy; n.r2 = disp_rs2_rdy;
      n.pn = disp_prd_new; n.po = disp_prd_old; n.ard = disp_ard;
      n.has_rd = disp_has_rd; n.fu = int'(disp_fu); n.pay = disp_payload;
      n.issued = 0; n.done = 0; n.data = '0;
      q.push_back(n);
    end
    ns = m_state;
    case (m_state)
      0: if (mispredict) ns = 1;
      1: if (size_now == 0) ns = 2;
      default: ns = 0;
    endcase
    m_state = ns;
    m_rec   = (ns == 2);
  endtask

  task automatic compare_all();
    bit exp_commit;
    exp_commit = (q.size() > 0) && q[0].done;
    check("disp_ready", 64'(disp_ready),
          64'((m_state == 0) && (q.size() < DEPTH) && !mispredict));
    check("commit", 64'(commit), 64'(exp_commit));
    if (exp_commit) begin
      check("commit_idx", 64'(commit_idx), 64'(q[0].idx));
      check("commit_wb_en", 64'(commit_wb_en), 64'(q[0].has_rd && q[0].ard != 0));
      check("commit_prd_new", 64'(commit_prd_new), 64'(q[0].pn));
      check("commit_prd_old", 64'(commit_prd_old), 64'(q[0].po));
      check("commit_ard", 64'(commit_ard), 64'(q[0].ard));
      check("commit_data", 64'(commit_data), 64'(q[0].data));
    end
    check("rob_count", 64'(rob_count), 64'(q.size()));
    check("rob_tail", 64'(rob_tail), 64'((m_head + q.size()) % DEPTH));
    check("recovery", 64'(recovery), 64'(m_rec));
    check("iss_valid", 64'(iss_valid), 64'(m_iss_v));
    check("iss_idx", 64'(iss_idx), 64'(m_iss_idx));
    check("iss_rs1", 64'(iss_rs1), 64'(m_iss_rs1));
    check("iss_rs2", 64'(iss_rs2), 64'(m_iss_rs2));
    check("iss_fu", 64'(iss_fu), 64'(m_iss_fu));
    check("iss_payload", iss_payload, m_iss_pay);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    disp_valid = 1'b0; disp_rs1 = '0; disp_rs2 = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
    disp_prd_new = '0; disp_prd_old = '0; disp_ard = '0; disp_has_rd = 1'b0; disp_fu = '0;
    disp_payload = '0; fu_ready = '0; wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
    mispredict = 1'b0; mis_idx = '0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      drive_random(cyc);
      #1;
      compare_all();
      model_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
